// File: rtl/meta_write_dispatcher_if.sv
// Handshake bundle for the metadata write dispatcher: one producer port and eight
// consumer ports. Consumer signals are packed per consumer index 0..7.
interface meta_write_dispatcher_if #(
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             io_in_valid;
    logic             io_in_ready;
    logic [2:0]       io_in_bits_dst;
    logic [5:0]       io_in_bits_idx;
    logic [7:0]       io_in_bits_way_en;
    logic [1:0]       io_in_bits_data_coh_state;
    logic [19:0]      io_in_bits_data_tag;

    logic [7:0]       io_out_valid;
    logic [7:0]       io_out_ready;
    logic [7:0][5:0]  io_out_bits_idx;
    logic [7:0][7:0]  io_out_bits_way_en;
    logic [7:0][1:0]  io_out_bits_data_coh_state;
    logic [7:0][19:0] io_out_bits_data_tag;

    logic [CNT_W-1:0] io_count;

    modport master (
        output io_in_valid, io_in_bits_dst, io_in_bits_idx, io_in_bits_way_en,
               io_in_bits_data_coh_state, io_in_bits_data_tag, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits_idx, io_out_bits_way_en,
               io_out_bits_data_coh_state, io_out_bits_data_tag, io_count
    );

    modport slave (
        input  io_in_valid, io_in_bits_dst, io_in_bits_idx, io_in_bits_way_en,
               io_in_bits_data_coh_state, io_in_bits_data_tag, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits_idx, io_out_bits_way_en,
               io_out_bits_data_coh_state, io_out_bits_data_tag, io_count
    );
endinterface

// File: rtl/meta_write_dispatcher.sv
// In-order FIFO that routes each metadata write to one of eight consumers selected
// by its dst field; the head entry blocks everything behind it until taken.
module meta_write_dispatcher #(
    parameter int DEPTH = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    meta_write_dispatcher_if.slave  io
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PAY_W = 36;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("DEPTH must be a power of two and at least 2");
    end

    logic [2:0]       dst_q [DEPTH];
    logic [PAY_W-1:0] pay_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             in_ready;
    logic             enq;
    logic             deq;
    logic [7:0]       out_valid;
    logic [2:0]       head_dst;
    logic [PAY_W-1:0] head_pay;

    // Ready depends only on registered occupancy, so a full queue refuses even
    // when the head is leaving this cycle.
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign enq      = io.io_in_valid & in_ready;

    assign head_dst  = dst_q[head_q];
    assign head_pay  = pay_q[head_q];
    assign out_valid = (count_q != '0) ? (8'b1 << head_dst) : 8'b0;
    assign deq       = |(out_valid & io.io_out_ready);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (deq) begin
            head_d = head_q + PTR_W'(1);
        end
        if (enq && !deq) begin
            count_d = count_q + CNT_W'(1);
        end else if (deq && !enq) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is unreset; occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        if (enq) begin
            dst_q[tail_q] <= io.io_in_bits_dst;
            pay_q[tail_q] <= {io.io_in_bits_idx, io.io_in_bits_way_en,
                              io.io_in_bits_data_coh_state, io.io_in_bits_data_tag};
        end
    end

    assign io.io_in_ready                = in_ready;
    assign io.io_out_valid               = out_valid;
    assign io.io_out_bits_idx            = {8{head_pay[35:30]}};
    assign io.io_out_bits_way_en         = {8{head_pay[29:22]}};
    assign io.io_out_bits_data_coh_state = {8{head_pay[21:20]}};
    assign io.io_out_bits_data_tag       = {8{head_pay[19:0]}};
    assign io.io_count                   = count_q;
endmodule

// File: tb/tb_meta_write_dispatcher.sv
// Directed bench for meta_write_dispatcher at DEPTH=2 with hand-computed expectations.
module tb_meta_write_dispatcher;
    localparam int DEPTH = 2;

    logic clock;
    logic reset;
    int   n_chk;
    int   n_err;

    meta_write_dispatcher_if #(.DEPTH(DEPTH)) io ();

    meta_write_dispatcher #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; drive and sample 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [2:0] dst, input logic [5:0] idx, input logic [19:0] tag);
        io.io_in_valid               = 1'b1;
        io.io_in_bits_dst            = dst;
        io.io_in_bits_idx            = idx;
        io.io_in_bits_way_en         = 8'h01;
        io.io_in_bits_data_coh_state = 2'd2;
        io.io_in_bits_data_tag       = tag;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        io.io_in_valid = 1'b0;
        io.io_in_bits_dst = '0;
        io.io_in_bits_idx = '0;
        io.io_in_bits_way_en = '0;
        io.io_in_bits_data_coh_state = '0;
        io.io_in_bits_data_tag = '0;
        io.io_out_ready = 8'h00;

        // Reset state
        #12;
        chk("rst_ready", 64'(io.io_in_ready), 64'd1);
        chk("rst_count", 64'(io.io_count), 64'd0);
        chk("rst_valid", 64'(io.io_out_valid), 64'h00);
        reset = 1'b1;
        tick();

        // Single write dst=3, consumer 3 ready
        io.io_out_ready = 8'h08;
        offer(3'd3, 6'h15, 20'hABCDE);
        chk("single_pre_valid", 64'(io.io_out_valid), 64'h00);
        tick();
        io.io_in_valid = 1'b0;
        chk("single_count1", 64'(io.io_count), 64'd1);
        chk("single_valid", 64'(io.io_out_valid), 64'h08);
        chk("single_idx", 64'(io.io_out_bits_idx[3]), 64'h15);
        chk("single_tag", 64'(io.io_out_bits_data_tag[3]), 64'hABCDE);
        chk("single_coh", 64'(io.io_out_bits_data_coh_state[3]), 64'd2);
        tick();
        chk("single_count0", 64'(io.io_count), 64'd0);
        chk("single_drained", 64'(io.io_out_valid), 64'h00);

        // Fill to full, third offer held, full-with-dequeue refuses
        io.io_out_ready = 8'h00;
        offer(3'd1, 6'h01, 20'h00001);
        tick();
        offer(3'd6, 6'h06, 20'h00006);
        tick();
        chk("fill_count2", 64'(io.io_count), 64'd2);
        chk("fill_ready0", 64'(io.io_in_ready), 64'd0);
        chk("fill_valid1", 64'(io.io_out_valid), 64'h02);
        chk("fill_idx1", 64'(io.io_out_bits_idx[1]), 64'h01);
        offer(3'd7, 6'h07, 20'h00007);
        tick();
        chk("held_count", 64'(io.io_count), 64'd2);
        chk("held_valid", 64'(io.io_out_valid), 64'h02);
        io.io_out_ready = 8'h02;
        tick();
        io.io_out_ready = 8'h00;
        chk("fulldeq_count1", 64'(io.io_count), 64'd1);
        chk("fulldeq_valid6", 64'(io.io_out_valid), 64'h40);
        chk("fulldeq_idx6", 64'(io.io_out_bits_idx[6]), 64'h06);
        chk("fulldeq_ready", 64'(io.io_in_ready), 64'd1);
        tick();
        io.io_in_valid = 1'b0;
        chk("resume_count2", 64'(io.io_count), 64'd2);
        io.io_out_ready = 8'hFF;
        tick();
        chk("drain_valid7", 64'(io.io_out_valid), 64'h80);
        chk("drain_idx7", 64'(io.io_out_bits_idx[7]), 64'h07);
        tick();
        chk("drain_count0", 64'(io.io_count), 64'd0);

        // Head-of-line blocking: consumer 5 ready, consumer 2 stalled
        io.io_out_ready = 8'h20;
        offer(3'd2, 6'h22, 20'h22222);
        tick();
        offer(3'd5, 6'h25, 20'h55555);
        tick();
        io.io_in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("hol_valid", 64'(io.io_out_valid), 64'h04);
            chk("hol_idx", 64'(io.io_out_bits_idx[2]), 64'h22);
            chk("hol_tag", 64'(io.io_out_bits_data_tag[2]), 64'h22222);
            chk("hol_count", 64'(io.io_count), 64'd2);
            tick();
        end
        io.io_out_ready = 8'hFF;
        tick();
        chk("hol_next_valid", 64'(io.io_out_valid), 64'h20);
        chk("hol_next_tag", 64'(io.io_out_bits_data_tag[5]), 64'h55555);
        tick();
        chk("hol_empty", 64'(io.io_count), 64'd0);

        // Streaming with every consumer ready
        for (int i = 0; i < 16; i++) begin
            offer(3'(i % 8), 6'(i + 8), 20'(i * 3));
            tick();
            chk("stream_count", 64'(io.io_count), 64'd1);
            chk("stream_valid", 64'(io.io_out_valid), 64'(8'b1 << (i % 8)));
            chk("stream_idx", 64'(io.io_out_bits_idx[i % 8]), 64'(i + 8));
            chk("stream_tag", 64'(io.io_out_bits_data_tag[i % 8]), 64'(i * 3));
        end
        io.io_in_valid = 1'b0;
        tick();
        chk("stream_end", 64'(io.io_count), 64'd0);

        // Asynchronous reset with a full queue
        io.io_out_ready = 8'h00;
        offer(3'd4, 6'h14, 20'h44444);
        tick();
        offer(3'd0, 6'h10, 20'h00010);
        tick();
        io.io_in_valid = 1'b0;
        chk("pre_arst_count", 64'(io.io_count), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 64'(io.io_out_valid), 64'h00);
        chk("arst_count", 64'(io.io_count), 64'd0);
        chk("arst_ready", 64'(io.io_in_ready), 64'd1);
        #1;
        reset = 1'b1;
        tick();
        chk("post_arst_valid", 64'(io.io_out_valid), 64'h00);
        chk("post_arst_count", 64'(io.io_count), 64'd0);
        offer(3'd5, 6'h3F, 20'hFFFFF);
        tick();
        io.io_in_valid = 1'b0;
        chk("first_enq_count", 64'(io.io_count), 64'd1);
        chk("first_enq_valid", 64'(io.io_out_valid), 64'h20);
        chk("first_enq_idx", 64'(io.io_out_bits_idx[5]), 64'h3F);
        io.io_out_ready = 8'hFF;
        tick();
        chk("final_count", 64'(io.io_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
